// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangle-sweep sequencer for an up/down counter (optional watchdog: UPDN_SWEEP_TIMEOUT_EN)
module updown_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int DWELL = 2,
    parameter int NSW_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic [NSW_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0] cnt,
    output logic             M,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NSW_W-1:0] sweep_cnt
);
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
    typedef enum logic [2:0] {IDLE, SEEK, UP, DWELL_HI, DOWN, DWELL_LO} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [NSW_W-1:0] nsw_q, sweep_inc;
    logic [DWW-1:0] dwell_q;
    logic at_lo, at_hi, legal, last, fin, tmo;
    assign at_lo = cnt == lo_q;
    assign at_hi = cnt == hi_q;
    assign legal = lo_lim < hi_lim;
    assign sweep_inc = sweep_cnt + 1'b1;
    assign last = (nsw_q != '0) && (sweep_inc == nsw_q);
    assign fin = (state == DOWN) && at_lo && !stop;
    assign busy = state != IDLE;
`ifdef UPDN_SWEEP_TIMEOUT_EN
    localparam logic [WIDTH+1:0] WD_MAX = (WIDTH+2)'((2**WIDTH) + 1);
    logic [WIDTH+1:0] wd;
`endif
    // next state and counter drive; stop overrides everything outside IDLE
    always_comb begin
        nxt = state;
        M = 1'b1;
        cnt_en = 1'b0;
        tmo = 1'b0;
        case (state)
            IDLE:     nxt = (start && legal) ? SEEK : IDLE;
            SEEK: begin
                M = cnt < lo_q;
                cnt_en = !at_lo;
                nxt = at_lo ? UP : SEEK;
            end
            UP: begin
                cnt_en = !at_hi;
                nxt = at_hi ? DWELL_HI : UP;
            end
            DWELL_HI: nxt = (dwell_q == '0) ? DOWN : DWELL_HI;
            DOWN: begin
                M = 1'b0;
                cnt_en = !at_lo;
                nxt = at_lo ? (last ? IDLE : DWELL_LO) : DOWN;
            end
            DWELL_LO: begin
                M = 1'b0;
                nxt = (dwell_q == '0) ? UP : DWELL_LO;
            end
            default:  nxt = IDLE;
        endcase
`ifdef UPDN_SWEEP_TIMEOUT_EN
        if ((state == SEEK || state == UP || state == DOWN) && nxt == state && wd == WD_MAX) begin
            tmo = 1'b1;
            nxt = IDLE;
        end
`endif
        if (state != IDLE && stop) begin
            nxt = IDLE;
            tmo = 1'b0;
        end
    end
    // state, latched run parameters, dwell timer and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lo_q <= '0;
            hi_q <= '0;
            nsw_q <= '0;
            dwell_q <= '0;
            sweep_cnt <= '0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= nxt;
            done <= fin && last;
            err <= tmo || (state == IDLE && start && !legal);
            dwell_q <= (state == DWELL_HI || state == DWELL_LO) ? dwell_q - 1'b1 : DWW'(DWELL - 1);
            if (state == IDLE && start && legal) begin
                lo_q <= lo_lim;
                hi_q <= hi_lim;
                nsw_q <= n_sweeps;
                sweep_cnt <= '0;
            end
            if (fin) sweep_cnt <= sweep_inc;
        end
    end
`ifdef UPDN_SWEEP_TIMEOUT_EN
    // watchdog restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd <= '0;
        else wd <= (nxt != state) ? '0 : wd + 1'b1;
    end
`endif
endmodule
